serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder controller for the LC-3 datapath.
- Captures two operands and a carry-in on a START handshake.
- Feeds one bit pair per clock, LSB first, into a single full_adder instance, with a registered carry between bits.
- Presents the assembled sum, carry-out and (optionally) LC-3 NZP condition codes when done. This gives area-minimal addition where latency is acceptable.

---
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : full_adder / serial_adder                                      |
// | Desc     : Bit-serial WIDTH-bit adder, LSB first, through one full adder. |
// |            Optional NZP condition-code output: SERIAL_ADDER_NZP_EN.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CYI,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             CYO
`ifdef SERIAL_ADDER_NZP_EN
    ,
    output logic [2:0]       NZP
`endif
);

    localparam int                 c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-2:0]   r_res_sh;

    logic               w_sum_bit;
    logic               w_cout;
    logic [WIDTH-1:0]   w_res_next;

    full_adder u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .sum  (w_sum_bit),
        .cout (w_cout)
    );

    // Result shifts in from the MSB; after WIDTH bits the LSB result sits at bit 0.
    assign w_res_next = {w_sum_bit, r_res_sh};

`ifdef SERIAL_ADDER_NZP_EN
    logic [2:0] w_nzp_next;
    assign w_nzp_next = w_sum_bit      ? 3'b100 :
                        (~|w_res_next) ? 3'b010 : 3'b001;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_res_sh <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            SUM      <= '0;
            CYO      <= 1'b0;
`ifdef SERIAL_ADDER_NZP_EN
            NZP      <= 3'b010;
`endif
        end else begin
            DONE <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_a_sh  <= A;
                        r_b_sh  <= B;
                        r_carry <= CYI;
                        r_cnt   <= '0;
                        BUSY    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry  <= w_cout;
                    r_res_sh <= w_res_next[WIDTH-1:1];
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        SUM     <= w_res_next;
                        CYO     <= w_cout;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        r_state <= S_IDLE;
`ifdef SERIAL_ADDER_NZP_EN
                        NZP     <= w_nzp_next;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_serial_adder                                               |
// | Desc     : Randomized self-checking bench for serial_adder.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_serial_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         cyi;
    logic         busy, done, cyo;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_NZP_EN
    logic [2:0]   nzp;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state: last completed result as the spec defines it.
    logic [W-1:0] m_sum;
    logic         m_cyo;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RST   (rst),
        .START (start),
        .A     (a),
        .B     (b),
        .CYI   (cyi),
        .BUSY  (busy),
        .DONE  (done),
        .SUM   (sum),
        .CYO   (cyo)
`ifdef SERIAL_ADDER_NZP_EN
        ,
        .NZP   (nzp)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] nzp_of(input logic [W-1:0] s);
        if (s[W-1])     return 3'b100;
        else if (s == 0) return 3'b010;
        else            return 3'b001;
    endfunction

    task automatic check_result(input string tag);
        check({tag, "_sum"}, 64'(sum), 64'(m_sum));
        check({tag, "_cyo"}, 64'(cyo), 64'(m_cyo));
`ifdef SERIAL_ADDER_NZP_EN
        check({tag, "_nzp"}, 64'(nzp), 64'(nzp_of(m_sum)));
`endif
    endtask

    // Caller is at posedge+1. Returns at posedge+1 of the DONE edge, START low.
    task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic ci, input bit disturb);
        logic [W:0] full;
        full  = {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
        a     = av;
        b     = bv;
        cyi   = ci;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c <= W; c++) begin
            if (c < W) begin
                check("run_busy", 64'(busy), 64'(1));
                check("run_done", 64'(done), 64'(0));
                check_result("run_hold");
            end else begin
                m_sum = full[W-1:0];
                m_cyo = full[W];
                check("end_busy", 64'(busy), 64'(0));
                check("end_done", 64'(done), 64'(1));
                check_result("end");
            end
            if (disturb && c == 3) begin
                a     = 16'hAAAA;
                b     = W'($urandom);
                cyi   = 1'($urandom);
                start = 1'b1;
            end
            if (disturb && c == 6) start = 1'b0;
            if (c < W) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cyi   = 1'b0;
        m_sum = '0;
        m_cyo = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check_result("rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run_add(16'h1234, 16'h4321, 1'b0, 1'b0);
        run_add(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_add(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        run_add(16'h00FF, 16'h0F0F, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++)
            run_add(W'($urandom), W'($urandom), 1'($urandom), (i % 3) == 0);

        // START held high: a new addition is accepted every WIDTH+1 edges.
        a     = 16'h0001;
        b     = 16'h0001;
        cyi   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 3 * (W + 1); c++) begin
            @(posedge clk); #1;
            check("b2b_done", 64'(done), 64'((c % (W + 1)) == W));
            check("b2b_busy", 64'(busy), 64'((c % (W + 1)) != W));
            if ((c % (W + 1)) == W) begin
                m_sum = 16'h0003;
                m_cyo = 1'b0;
                check_result("b2b");
            end
        end
        start = 1'b0;
        // Let the last accepted addition drain.
        repeat (W + 2) @(posedge clk);
        #1;

        // Abort mid-operation with an asynchronous reset.
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        cyi   = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        m_sum = '0;
        m_cyo = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check_result("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < W + 2; c++) begin
            @(posedge clk); #1;
            check("post_abort_done", 64'(done), 64'(0));
            check("post_abort_busy", 64'(busy), 64'(0));
            check_result("post_abort");
        end
        run_add(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

        @(posedge clk); #1;
        check("final_done_low", 64'(done), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
